pcpi_issuer: RTL and testbench

Initiator side of the PCPI coprocessor interface. It accepts one instruction at a time from the core pipeline over a valid/ready request channel and presents it on PCPI. It then waits for the coprocessor (e.g. the M-extension unit) to complete and returns the result, or an illegal-instruction response, on a valid/ready response channel. It sits between the core's execute stage and every PCPI responder.

---
 rtl/pcpi_issuer.sv | 119 +++++++++++
 tb/tb_pcpi_issuer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_issuer.sv
// PCPI initiator: issues one instruction at a time to the coprocessor bus and
// returns the result, or an illegal-instruction response on timeout, to the core.
module pcpi_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_wr,
    output logic [31:0] resp_rd,
    output logic        resp_illegal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             capture;
    logic             timeout;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A same-cycle ready wins over busy so single-cycle responders skip WAIT.
                if (pcpi_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (pcpi_busy) begin
                    state_nxt = S_WAIT;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (pcpi_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pcpi_insn    <= '0;
            pcpi_rs1     <= '0;
            pcpi_rs2     <= '0;
            resp_wr      <= 1'b0;
            resp_rd      <= '0;
            resp_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                pcpi_insn <= req_insn;
                pcpi_rs1  <= req_rs1;
                pcpi_rs2  <= req_rs2;
            end
            if (capture) begin
                resp_wr      <= pcpi_wr;
                resp_rd      <= pcpi_wr ? pcpi_rd : '0;
                resp_illegal <= 1'b0;
            end else if (timeout) begin
                resp_wr      <= 1'b0;
                resp_rd      <= '0;
                resp_illegal <= 1'b1;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign pcpi_valid = (state == S_ISSUE) || (state == S_WAIT);
    assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_pcpi_issuer.sv
// Directed bench for pcpi_issuer: the bench plays both core and coprocessor.
module tb_pcpi_issuer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_busy, pcpi_ready, pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        resp_valid, resp_ready, resp_wr, resp_illegal;
    logic [31:0] resp_rd;

    int checks = 0;
    int errors = 0;

    pcpi_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_wr(resp_wr), .resp_rd(resp_rd), .resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic responder(input logic busy, input logic rdy, input logic wr, input logic [31:0] rd);
        pcpi_busy  = busy;
        pcpi_ready = rdy;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int idx;
        logic ok;

        resetn = 1'b0;
        req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        resp_ready = 1'b0;
        responder(1'b0, 1'b0, 1'b0, '0);
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_wr", 32'(resp_wr), 32'd0);
        chk("rst_resp_illegal", 32'(resp_illegal), 32'd0);
        chk("rst_resp_rd", resp_rd, 32'd0);
        chk("rst_pcpi_insn", pcpi_insn, 32'd0);
        resetn = 1'b1;
        tick();

        // MUL 7*6: busy one cycle, then ready with 42
        send(32'h02c5_8533, 32'd7, 32'd6);
        chk("mul_pcpi_valid", 32'(pcpi_valid), 32'd1);
        chk("mul_req_ready", 32'(req_ready), 32'd0);
        chk("mul_insn", pcpi_insn, 32'h02c5_8533);
        chk("mul_rs1", pcpi_rs1, 32'd7);
        chk("mul_rs2", pcpi_rs2, 32'd6);
        responder(1'b1, 1'b0, 1'b0, '0);
        tick();
        responder(1'b0, 1'b1, 1'b1, 32'd42);
        chk("mul_wait_valid", 32'(pcpi_valid), 32'd1);
        chk("mul_wait_rs2", pcpi_rs2, 32'd6);
        tick();
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("mul_resp_valid", 32'(resp_valid), 32'd1);
        chk("mul_pcpi_drop", 32'(pcpi_valid), 32'd0);
        chk("mul_resp_wr", 32'(resp_wr), 32'd1);
        chk("mul_resp_rd", resp_rd, 32'd42);
        chk("mul_resp_illegal", 32'(resp_illegal), 32'd0);
        release_resp();
        chk("mul_back_idle", 32'(req_ready), 32'd1);
        chk("mul_resp_clear", 32'(resp_valid), 32'd0);

        // DIV -20/3: busy 35 cycles, busy low 1 cycle, then ready with -6
        send(32'h02c5_c533, 32'hFFFF_FFEC, 32'd3);
        responder(1'b1, 1'b0, 1'b0, '0);
        ok = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (!pcpi_valid || resp_valid) ok = 1'b0;
        end
        chk("div_busy_hold", 32'(ok), 32'd1);
        responder(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("div_no_timeout", 32'(pcpi_valid), 32'd1);
        responder(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA);
        tick();
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("div_resp_valid", 32'(resp_valid), 32'd1);
        chk("div_resp_rd", resp_rd, 32'hFFFF_FFFA);
        chk("div_resp_wr", 32'(resp_wr), 32'd1);
        release_resp();

        // Unclaimed opcode: illegal response in cycle 17 after acceptance
        send(32'h0000_000b, 32'd1, 32'd2);
        idx = 1;
        while (!resp_valid && idx < 100) begin
            tick();
            idx++;
        end
        chk("to_latency", 32'(idx), 32'd17);
        chk("to_illegal", 32'(resp_illegal), 32'd1);
        chk("to_resp_wr", 32'(resp_wr), 32'd0);
        chk("to_resp_rd", resp_rd, 32'd0);
        chk("to_pcpi_valid", 32'(pcpi_valid), 32'd0);
        release_resp();

        // ready+busy in first ISSUE cycle with wr=0: straight to RESP, rd masked
        send(32'h0000_002b, 32'd3, 32'd4);
        responder(1'b1, 1'b1, 1'b0, 32'h55);
        tick();
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("rb_resp_valid", 32'(resp_valid), 32'd1);
        chk("rb_resp_wr", 32'(resp_wr), 32'd0);
        chk("rb_resp_rd", resp_rd, 32'd0);
        chk("rb_illegal", 32'(resp_illegal), 32'd0);
        release_resp();

        // Back-pressure: resp_ready low 10 cycles with a request waiting
        send(32'h02c5_8533, 32'd2, 32'd3);
        responder(1'b0, 1'b1, 1'b1, 32'h1234);
        tick();
        responder(1'b0, 1'b1, 1'b1, 32'h9999);
        req_valid = 1'b1; req_insn = 32'h02c5_d533; req_rs1 = 32'd100; req_rs2 = 32'd7;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!resp_valid || req_ready || !resp_wr || resp_rd !== 32'h1234 ||
                pcpi_insn !== 32'h02c5_8533 || pcpi_valid) ok = 1'b0;
            tick();
        end
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("bp_stable", 32'(ok), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_req_ready", 32'(req_ready), 32'd1);
        chk("bp_old_insn", pcpi_insn, 32'h02c5_8533);
        tick();
        req_valid = 1'b0;
        chk("bp_accept", 32'(pcpi_valid), 32'd1);
        chk("bp_new_insn", pcpi_insn, 32'h02c5_d533);

        // Reset in the middle of WAIT; a late ready afterwards is ignored
        responder(1'b1, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("rw_in_wait", 32'(pcpi_valid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rw_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("rw_pcpi_rs1", pcpi_rs1, 32'd0);
        chk("rw_resp_rd", resp_rd, 32'd0);
        chk("rw_resp_wr", 32'(resp_wr), 32'd0);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        tick();
        resetn = 1'b1;
        responder(1'b0, 1'b1, 1'b1, 32'hDEAD);
        tick();
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("rw_late_ignored", 32'(resp_valid), 32'd0);
        chk("rw_idle", 32'(req_ready), 32'd1);
        send(32'h02c5_8533, 32'd5, 32'd5);
        chk("rw_next_issue", 32'(pcpi_valid), 32'd1);
        chk("rw_next_rs1", pcpi_rs1, 32'd5);
        responder(1'b0, 1'b1, 1'b1, 32'd25);
        tick();
        responder(1'b0, 1'b0, 1'b0, '0);
        chk("rw_next_rd", resp_rd, 32'd25);
        release_resp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
